// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register feeding the EX-stage ALU: decodes ALUOp/funct to the
// 3-bit ALU control, holds operands/control across the boundary and forwards.
module id_ex_alu_issue #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [1:0]            id_alu_op,
  input  logic [5:0]            id_funct,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic [WIDTH-1:0]      id_rs_data,
  input  logic [WIDTH-1:0]      id_rt_data,
  input  logic [WIDTH-1:0]      id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [1:0]            fwd_a,
  input  logic [1:0]            fwd_b,
  input  logic [WIDTH-1:0]      exmem_data,
  input  logic [WIDTH-1:0]      memwb_data,
  output logic [WIDTH-1:0]      ex_alu_a,
  output logic [WIDTH-1:0]      ex_alu_b,
  output logic [2:0]            ex_alu_ctrl,
  output logic [WIDTH-1:0]      ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_wb_reg,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_valid,
  output logic                  ex_illegal
);

  localparam logic [2:0] C_AND = 3'b000;
  localparam logic [2:0] C_OR  = 3'b001;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_SUB = 3'b011;
  localparam logic [2:0] C_MUL = 3'b100;

  logic [2:0]            w_dec_ctrl;
  logic                  w_dec_illegal;
  logic [REG_ADDR_W-1:0] w_wb_reg;
  logic [WIDTH-1:0]      w_fwd_rt;

  logic [WIDTH-1:0]      r_rs_data;
  logic [WIDTH-1:0]      r_rt_data;
  logic [WIDTH-1:0]      r_imm;
  logic                  r_alu_src;
  logic [2:0]            r_alu_ctrl;
  logic [REG_ADDR_W-1:0] r_wb_reg;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_to_reg;
  logic                  r_valid;
  logic                  r_illegal;

  // 00 and 11 both select the value already held in ID/EX.
  function automatic logic [WIDTH-1:0] fwd_mux(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] idex_val,
    input logic [WIDTH-1:0] exmem_val,
    input logic [WIDTH-1:0] memwb_val
  );
    case (sel)
      2'b01:   fwd_mux = memwb_val;
      2'b10:   fwd_mux = exmem_val;
      default: fwd_mux = idex_val;
    endcase
  endfunction

  // ALU control decode from main-decoder ALUOp and funct
  always_comb begin
    w_dec_ctrl    = C_ADD;
    w_dec_illegal = 1'b0;
    case (id_alu_op)
      2'b00: w_dec_ctrl = C_ADD;
      2'b01: w_dec_ctrl = C_SUB;
      2'b10: begin
        case (id_funct)
          6'b100000: w_dec_ctrl = C_ADD;
          6'b100010: w_dec_ctrl = C_SUB;
          6'b100100: w_dec_ctrl = C_AND;
          6'b100101: w_dec_ctrl = C_OR;
          6'b011000: w_dec_ctrl = C_MUL;
          default: begin
            w_dec_ctrl    = C_ADD;
            w_dec_illegal = id_valid;
          end
        endcase
      end
      default: w_dec_ctrl = C_ADD;
    endcase
  end

  assign w_wb_reg = id_reg_dst ? id_rd : id_rt;

  // ID/EX boundary register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= C_ADD;
      r_wb_reg     <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (!stall) begin
      r_rs_data    <= id_rs_data;
      r_rt_data    <= id_rt_data;
      r_imm        <= id_imm;
      r_alu_src    <= id_alu_src;
      r_alu_ctrl   <= w_dec_ctrl;
      r_wb_reg     <= w_wb_reg;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      // Side-effecting controls are dropped for an empty ID slot.
      r_reg_write  <= id_reg_write & id_valid;
      r_mem_read   <= id_mem_read & id_valid;
      r_mem_write  <= id_mem_write & id_valid;
      r_mem_to_reg <= id_mem_to_reg;
      r_valid      <= id_valid;
      r_illegal    <= w_dec_illegal;
    end
  end

  // Forwarding after the register so bypassed results add no latency
  always_comb begin
    w_fwd_rt      = fwd_mux(fwd_b, r_rt_data, exmem_data, memwb_data);
    ex_alu_a      = fwd_mux(fwd_a, r_rs_data, exmem_data, memwb_data);
    ex_alu_b      = r_alu_src ? r_imm : w_fwd_rt;
    ex_store_data = w_fwd_rt;
  end

  assign ex_alu_ctrl   = r_alu_ctrl;
  assign ex_wb_reg     = r_wb_reg;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_valid      = r_valid;
  assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Table-driven bench for id_ex_alu_issue: directed vectors with hand-computed
// expectations, plus sequences for reset-during-stall and flush-only.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] exmem_data, memwb_data;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
  logic [2:0]  ex_alu_ctrl;
  logic [4:0]  ex_wb_reg, ex_rs, ex_rt;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid, ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .exmem_data(exmem_data), .memwb_data(memwb_data),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_store_data(ex_store_data), .ex_wb_reg(ex_wb_reg), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_valid(ex_valid), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        rst, stall, flush, valid;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src, reg_dst, rw, mr, mw, m2r;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  fa, fb;
    logic [31:0] exmem, memwb;
  } vin_t;

  typedef struct packed {
    logic [31:0] a, b, store;
    logic [2:0]  ctrl;
    logic [4:0]  wb, rs, rt;
    logic        rw, mr, mw, m2r, valid, ill;
  } vexp_t;

  typedef struct packed {
    vin_t  i;
    vexp_t e;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vin_t vi_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    vin_t v = '0;
    v.valid = 1'b1; v.alu_op = 2'b10; v.funct = f; v.reg_dst = 1'b1; v.rw = 1'b1;
    v.rs_d = a; v.rt_d = b; v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd3;
    return v;
  endfunction

  function automatic vexp_t ve_r(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    vexp_t e = '0;
    e.a = a; e.b = b; e.store = b; e.ctrl = c; e.wb = 5'd3; e.rs = 5'd1; e.rt = 5'd2;
    e.rw = 1'b1; e.valid = 1'b1;
    return e;
  endfunction

  function automatic vexp_t ve_reset();
    vexp_t e = '0;
    e.ctrl = 3'b010;
    return e;
  endfunction

  task automatic drive(input vin_t v);
    rst = v.rst; stall = v.stall; flush = v.flush; id_valid = v.valid;
    id_alu_op = v.alu_op; id_funct = v.funct; id_alu_src = v.alu_src; id_reg_dst = v.reg_dst;
    id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw; id_mem_to_reg = v.m2r;
    id_rs_data = v.rs_d; id_rt_data = v.rt_d; id_imm = v.imm;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; fwd_a = v.fa; fwd_b = v.fb;
    exmem_data = v.exmem; memwb_data = v.memwb;
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, fld, act, exp);
    end
  endtask

  task automatic check(input string tag, input vexp_t e);
    chk(tag, "alu_a", ex_alu_a, e.a);
    chk(tag, "alu_b", ex_alu_b, e.b);
    chk(tag, "store", ex_store_data, e.store);
    chk(tag, "ctrl", {29'd0, ex_alu_ctrl}, {29'd0, e.ctrl});
    chk(tag, "wb_reg", {27'd0, ex_wb_reg}, {27'd0, e.wb});
    chk(tag, "ex_rs", {27'd0, ex_rs}, {27'd0, e.rs});
    chk(tag, "ex_rt", {27'd0, ex_rt}, {27'd0, e.rt});
    chk(tag, "ctl_bits",
        {26'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid, ex_illegal},
        {26'd0, e.rw, e.mr, e.mw, e.m2r, e.valid, e.ill});
  endtask

  task automatic step(input vin_t v);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vin_t  vi;
    vexp_t ve;
    vin_t  v_lw;
    vexp_t e_lw;
    vexp_t e_fw;

    // R-type sweep
    vecs[0].i = vi_r(6'b100000, 32'd200, 32'd100); vecs[0].e = ve_r(3'b010, 32'd200, 32'd100);
    vecs[1].i = vi_r(6'b100100, 32'd200, 32'd100); vecs[1].e = ve_r(3'b000, 32'd200, 32'd100);
    vecs[2].i = vi_r(6'b100101, 32'd200, 32'd100); vecs[2].e = ve_r(3'b001, 32'd200, 32'd100);
    vecs[3].i = vi_r(6'b100010, 32'd200, 32'd100); vecs[3].e = ve_r(3'b011, 32'd200, 32'd100);
    vecs[4].i = vi_r(6'b011000, 32'd200, 32'd100); vecs[4].e = ve_r(3'b100, 32'd200, 32'd100);
    vecs[5].i = vi_r(6'b111111, 32'd200, 32'd100); vecs[5].e = ve_r(3'b010, 32'd200, 32'd100);
    vecs[5].e.ill = 1'b1;

    // lw rt=8 <- 1000 + (-4)
    v_lw = '0;
    v_lw.valid = 1'b1; v_lw.alu_op = 2'b00; v_lw.alu_src = 1'b1; v_lw.imm = 32'hFFFF_FFFC;
    v_lw.rs_d = 32'd1000; v_lw.rt_d = 32'd55; v_lw.rs = 5'd4; v_lw.rt = 5'd8; v_lw.rd = 5'd9;
    v_lw.rw = 1'b1; v_lw.mr = 1'b1; v_lw.m2r = 1'b1;
    e_lw = '0;
    e_lw.a = 32'd1000; e_lw.b = 32'hFFFF_FFFC; e_lw.store = 32'd55; e_lw.ctrl = 3'b010;
    e_lw.wb = 5'd8; e_lw.rs = 5'd4; e_lw.rt = 5'd8;
    e_lw.rw = 1'b1; e_lw.mr = 1'b1; e_lw.m2r = 1'b1; e_lw.valid = 1'b1;
    vecs[6].i = v_lw; vecs[6].e = e_lw;
    for (int k = 7; k < 10; k++) begin
      vecs[k].i = vi_r(6'b100010, 32'd77 + k, 32'd88);
      vecs[k].i.stall = 1'b1;
      vecs[k].e = e_lw;
    end

    // Released: ALUOp 01 decodes to SUB
    vi = vi_r(6'b100000, 32'd5, 32'd6); vi.alu_op = 2'b01; vi.rw = 1'b0;
    ve = ve_r(3'b011, 32'd5, 32'd6); ve.rw = 1'b0;
    vecs[10].i = vi; vecs[10].e = ve;

    // Forwarding on a freshly loaded R-type
    vi = vi_r(6'b100000, 32'd10, 32'd20);
    vi.fa = 2'b10; vi.exmem = 32'd7; vi.fb = 2'b01; vi.memwb = 32'd9;
    e_fw = ve_r(3'b010, 32'd7, 32'd9);
    vecs[11].i = vi; vecs[11].e = e_fw;
    // Held, fwd 11 selects the ID/EX value
    vi = vi_r(6'b100100, 32'd1, 32'd2); vi.stall = 1'b1;
    vi.fa = 2'b11; vi.fb = 2'b11; vi.exmem = 32'd7; vi.memwb = 32'd9;
    vecs[12].i = vi; vecs[12].e = ve_r(3'b010, 32'd10, 32'd20);

    // sw: B is imm, store data forwarded from EX/MEM
    vi = '0;
    vi.valid = 1'b1; vi.alu_op = 2'b11; vi.alu_src = 1'b1; vi.imm = 32'd16;
    vi.rs_d = 32'd100; vi.rt_d = 32'd33; vi.rs = 5'd5; vi.rt = 5'd6; vi.rd = 5'd7;
    vi.mw = 1'b1; vi.fb = 2'b10; vi.exmem = 32'd7;
    ve = '0;
    ve.a = 32'd100; ve.b = 32'd16; ve.store = 32'd7; ve.ctrl = 3'b010;
    ve.wb = 5'd6; ve.rs = 5'd5; ve.rt = 5'd6; ve.mw = 1'b1; ve.valid = 1'b1;
    vecs[13].i = vi; vecs[13].e = ve;

    // Flush and stall together: flush wins, bubble loaded
    vi = vi_r(6'b111111, 32'd123, 32'd456); vi.mw = 1'b1; vi.mr = 1'b1;
    vi.flush = 1'b1; vi.stall = 1'b1;
    vecs[14].i = vi; vecs[14].e = ve_reset();

    // Invalid ID slot loads as a bubble
    vi = '0; vi.alu_op = 2'b00; vi.rw = 1'b1; vi.mr = 1'b1; vi.mw = 1'b1;
    vecs[15].i = vi; vecs[15].e = ve_reset();
    vi = '0; vi.alu_op = 2'b10; vi.funct = 6'b111111; vi.rw = 1'b1;
    vecs[16].i = vi; vecs[16].e = ve_reset();

    // Reset state
    vi = '0; vi.rst = 1'b1;
    step(vi);
    check("reset", ve_reset());
    vi = '0;
    step(vi);
    check("idle", ve_reset());

    for (int n = 0; n < NV; n++) begin
      step(vecs[n].i);
      check($sformatf("vec%0d", n), vecs[n].e);
    end

    // Reset while stalled with a valid instruction held
    step(v_lw);
    check("pre_rst_load", e_lw);
    vi = v_lw; vi.stall = 1'b1;
    step(vi);
    check("pre_rst_hold", e_lw);
    vi.rst = 1'b1;
    step(vi);
    check("rst_in_stall", ve_reset());

    // Flush alone after a load
    step(v_lw);
    check("pre_flush", e_lw);
    vi = v_lw; vi.flush = 1'b1;
    step(vi);
    check("flush_only", ve_reset());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
